// File: rtl/alu_arbiter_if.sv
// Bundle of requester-side and ALU-side signals for the two-requester ALU arbiter.
// Latency: none (wires only).
// Backpressure: requesters hold req until granted; done is the only completion indication.
interface alu_arbiter_if #(
    parameter int OPND_W = 4,
    parameter int RES_W  = 8
);
    logic              req0;
    logic              req1;
    logic [2:0]        op0;
    logic [2:0]        op1;
    logic [OPND_W-1:0] a0;
    logic [OPND_W-1:0] b0;
    logic [OPND_W-1:0] a1;
    logic [OPND_W-1:0] b1;
    logic              done0;
    logic              done1;
    logic [RES_W-1:0]  res0;
    logic [RES_W-1:0]  res1;
    logic              alu_en;
    logic [7:0]        alu_opcode;
    logic [OPND_W-1:0] alu_in_1;
    logic [OPND_W-1:0] alu_in_2;
    logic [RES_W-1:0]  alu_out;
    logic              busy;

    // Requester/ALU side: drives requests and the registered ALU result.
    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, alu_out,
        input  done0, done1, res0, res1, alu_en, alu_opcode, alu_in_1, alu_in_2, busy
    );

    // Arbiter side.
    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, alu_out,
        output done0, done1, res0, res1, alu_en, alu_opcode, alu_in_1, alu_in_2, busy
    );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters (round-robin, or fixed priority with ALU_ARB_FIXED_PRIO_EN).
// Latency: req in IDLE cycle N -> alu_en cycle N+1 -> done/res visible cycle N+3.
// Backpressure: a losing requester keeps req high and is served in the next IDLE; no request is dropped.
module alu_arbiter #(
    parameter int OPND_W = 4,
    parameter int RES_W  = 8
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              gnt_q;      // identity of the requester in flight
    logic              gnt_id;     // requester that would win in this IDLE cycle
    logic              any_req;
    logic [2:0]        op_q;
    logic [OPND_W-1:0] a_q;
    logic [OPND_W-1:0] b_q;
    logic [RES_W-1:0]  res0_q;
    logic [RES_W-1:0]  res1_q;

    assign any_req = bus.req0 | bus.req1;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Requester 0 wins whenever it asks.
    always_comb begin
        gnt_id = ~bus.req0;
    end
`else
    logic last_grant_q;

    // Tie goes to whoever was not served last; a lone request is served directly.
    always_comb begin
        gnt_id = (bus.req0 && bus.req1) ? ~last_grant_q : ~bus.req0;
    end

    // Remember the most recent grant; only moves when a grant is made.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (state_q == IDLE && any_req) begin
            last_grant_q <= gnt_id;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave IDLE on any request, then walk the fixed pipeline back.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = any_req ? ISSUE : IDLE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winner's command at grant; later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q <= 1'b0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (state_q == IDLE && any_req) begin
            gnt_q <= gnt_id;
            op_q  <= gnt_id ? bus.op1 : bus.op0;
            a_q   <= gnt_id ? bus.a1  : bus.a0;
            b_q   <= gnt_id ? bus.b1  : bus.b0;
        end
    end

    // Capture the ALU result for the requester in flight; the other result is untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            res0_q <= '0;
            res1_q <= '0;
        end else if (state_q == WAIT) begin
            if (gnt_q) begin
                res1_q <= bus.alu_out;
            end else begin
                res0_q <= bus.alu_out;
            end
        end
    end

    // Outputs decoded from state; ALU operands always reflect the last latched command.
    always_comb begin
        bus.alu_en     = (state_q == ISSUE);
        bus.alu_opcode = {5'b0, op_q};
        bus.alu_in_1   = a_q;
        bus.alu_in_2   = b_q;
        bus.done0      = (state_q == DONE) && !gnt_q;
        bus.done1      = (state_q == DONE) &&  gnt_q;
        bus.busy       = (state_q != IDLE);
        bus.res0       = res0_q;
        bus.res1       = res1_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected (requester, result) pairs,
// a negedge monitor pops one entry per done pulse. The bench also plays the registered ALU.
// ALU ops modelled here: 0 pass a, 1 add, 2 sub, 3 mul, 4 or, 5 and, 6 xor, 7 pass b.
module tb_alu_arbiter;

    localparam int OPND_W = 4;
    localparam int RES_W  = 8;

    logic clk;
    logic rst;

    alu_arbiter_if #(.OPND_W(OPND_W), .RES_W(RES_W)) bus ();

    alu_arbiter #(.OPND_W(OPND_W), .RES_W(RES_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         id;
        logic [7:0] res;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RES_W-1:0] alu_f(input logic [7:0] op,
                                               input logic [OPND_W-1:0] a,
                                               input logic [OPND_W-1:0] b);
        logic [RES_W-1:0] ea;
        logic [RES_W-1:0] eb;
        ea = RES_W'(a);
        eb = RES_W'(b);
        case (op)
            8'd0:    return ea;
            8'd1:    return ea + eb;
            8'd2:    return ea - eb;
            8'd3:    return ea * eb;
            8'd4:    return ea | eb;
            8'd5:    return ea & eb;
            8'd6:    return ea ^ eb;
            default: return eb;
        endcase
    endfunction

    // Registered ALU model: result valid the cycle after alu_en.
    always @(posedge clk) begin
        if (bus.alu_en) bus.alu_out <= alu_f(bus.alu_opcode, bus.alu_in_1, bus.alu_in_2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && (bus.done0 || bus.done1)) begin
            exp_t e;
            chk("done_onehot", {31'b0, bus.done0 & bus.done1}, 32'd0);
            if (sb.size() == 0) begin
                chk("spurious_done", {31'b0, bus.done1}, 32'd2);
            end else begin
                e = sb.pop_front();
                chk("done_id", {31'b0, bus.done1}, e.id);
                chk("done_res", bus.done1 ? bus.res1 : bus.res0, e.res);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [7:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        sb.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 20) begin
            tick();
            n++;
        end
        if (bus.busy) chk("idle_timeout", {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        int n;
        checks = 0;
        errors = 0;
        bus.req0 = 0; bus.req1 = 0;
        bus.op0 = 0; bus.op1 = 0;
        bus.a0 = 0; bus.b0 = 0; bus.a1 = 0; bus.b1 = 0;
        bus.alu_out = 0;

        // Reset state.
        do_reset();
        chk("rst_busy",   {31'b0, bus.busy},   32'd0);
        chk("rst_alu_en", {31'b0, bus.alu_en}, 32'd0);
        chk("rst_opcode", bus.alu_opcode, 32'd0);
        chk("rst_in1",    bus.alu_in_1, 32'd0);
        chk("rst_in2",    bus.alu_in_2, 32'd0);
        chk("rst_done",   {30'b0, bus.done1, bus.done0}, 32'd0);
        chk("rst_res0",   bus.res0, 32'd0);
        chk("rst_res1",   bus.res1, 32'd0);

        // Single request: 3+5 via op 1, timing N -> N+1 -> N+3.
        bus.req0 = 1; bus.op0 = 3'd1; bus.a0 = 4'd3; bus.b0 = 4'd5;
        push(0, 8'd8);
        tick();
        bus.req0 = 0;
        chk("issue_alu_en", {31'b0, bus.alu_en}, 32'd1);
        chk("issue_opcode", bus.alu_opcode, 32'h01);
        chk("issue_in1", bus.alu_in_1, 32'd3);
        chk("issue_in2", bus.alu_in_2, 32'd5);
        tick();
        chk("wait_alu_en", {31'b0, bus.alu_en}, 32'd0);
        chk("wait_opcode_hold", bus.alu_opcode, 32'h01);
        chk("wait_busy", {31'b0, bus.busy}, 32'd1);
        tick();
        chk("done_cycle_n3", {31'b0, bus.done0}, 32'd1);
        tick();
        chk("back_idle", {31'b0, bus.busy}, 32'd0);
        chk("done_cleared", {31'b0, bus.done0}, 32'd0);

        // Requester 1 completes with 12; requester 0 keeps its 8.
        bus.req1 = 1; bus.op1 = 3'd1; bus.a1 = 4'd7; bus.b1 = 4'd5;
        push(1, 8'd12);
        tick();
        bus.req1 = 0;
        wait_idle();
        chk("res0_held", bus.res0, 32'd8);
        chk("res1_12", bus.res1, 32'd12);

        // Simultaneous requests after reset: requester 0 first, then 1.
        do_reset();
        bus.req0 = 1; bus.op0 = 3'd1; bus.a0 = 4'd2;  bus.b0 = 4'd2;
        bus.req1 = 1; bus.op1 = 3'd5; bus.a1 = 4'd12; bus.b1 = 4'd10;
        push(0, 8'd4);
        push(1, 8'd8);
        tick();
        bus.req0 = 0;
        chk("tie_first_in1", bus.alu_in_1, 32'd2);
        n = 0;
        while (!(bus.alu_en && bus.alu_in_1 == 4'd12) && n < 20) begin
            tick();
            n++;
        end
        chk("tie_second_issued", {31'b0, bus.alu_en}, 32'd1);
        bus.req1 = 0;
        wait_idle();
        chk("tie_res0", bus.res0, 32'd4);
        chk("tie_res1", bus.res1, 32'd8);

        // Both held for four transactions.
        do_reset();
        bus.req0 = 1; bus.op0 = 3'd1; bus.a0 = 4'd1; bus.b0 = 4'd1;
        bus.req1 = 1; bus.op1 = 3'd1; bus.a1 = 4'd3; bus.b1 = 4'd3;
`ifdef ALU_ARB_FIXED_PRIO_EN
        push(0, 8'd2); push(0, 8'd2); push(0, 8'd2); push(0, 8'd2);
`else
        push(0, 8'd2); push(1, 8'd6); push(0, 8'd2); push(1, 8'd6);
`endif
        cnt = 0;
        n = 0;
        while (cnt < 4 && n < 40) begin
            tick();
            n++;
            if (bus.done0 || bus.done1) cnt++;
        end
        bus.req0 = 0;
        bus.req1 = 0;
        chk("held_count", cnt, 32'd4);
        wait_idle();

        // Operand change after grant must not disturb the transaction: 9-4.
        bus.req1 = 1; bus.op1 = 3'd2; bus.a1 = 4'd9; bus.b1 = 4'd4;
        push(1, 8'd5);
        tick();
        bus.req1 = 0; bus.a1 = 4'd0; bus.op1 = 3'd0;
        wait_idle();
        chk("late_change_res1", bus.res1, 32'd5);

        // Reset in WAIT aborts: no done, result stays cleared.
        do_reset();
        bus.req0 = 1; bus.op0 = 3'd1; bus.a0 = 4'd3; bus.b0 = 4'd5;
        tick();
        bus.req0 = 0;
        tick();
        chk("abort_in_wait_busy", {31'b0, bus.busy}, 32'd1);
        rst = 1;
        tick();
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {30'b0, bus.done1, bus.done0}, 32'd0);
        chk("abort_res0", bus.res0, 32'd0);
        rst = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_res0_later", bus.res0, 32'd0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
